// File: rtl/exu_port_scheduler_pkg.sv
// rtl/exu_port_scheduler_pkg.sv - shared ROB age types and age-compare helper
// Used by the port scheduler, its interface and its picker.
package exu_port_scheduler_pkg;

   localparam int ROB_SIZE_LOG = 6;

   typedef struct packed {
      logic                    flag;
      logic [ROB_SIZE_LOG-1:0] idx;
   } age_tag_t;

   // ROB wrap flag inverts the index ordering between the two halves of the ring
   function automatic logic is_older(input logic                    flag_a,
                                     input logic [ROB_SIZE_LOG-1:0] idx_a,
                                     input logic                    flag_b,
                                     input logic [ROB_SIZE_LOG-1:0] idx_b);
      return (flag_a == flag_b) ? (idx_a < idx_b) : (idx_a > idx_b);
   endfunction

endpackage

// File: rtl/exu_port_scheduler_if.sv
// rtl/exu_port_scheduler_if.sv - issue-queue / EXU side signals of the port scheduler
// slave is the scheduler; master is the queues plus execute block.
interface exu_port_scheduler_if
   import exu_port_scheduler_pkg::*;
#(
   parameter int NUM_REQ = 4
);
   localparam int IDX_W = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0]              req_valid;
   logic [NUM_REQ-1:0]              req_is_muldiv;
   logic [NUM_REQ-1:0]              req_robidx_flag;
   logic [NUM_REQ*ROB_SIZE_LOG-1:0] req_robidx;
   logic [NUM_REQ-1:0]              req_ready;
   logic                            exu_ready;
   logic                            flush_valid;
   logic                            grant_valid;
   logic [IDX_W-1:0]                grant_idx;
   logic                            grant_is_muldiv;
   logic                            port_busy;

   modport master (
      output req_valid, req_is_muldiv, req_robidx_flag, req_robidx, exu_ready, flush_valid,
      input  req_ready, grant_valid, grant_idx, grant_is_muldiv, port_busy
   );

   modport slave (
      input  req_valid, req_is_muldiv, req_robidx_flag, req_robidx, exu_ready, flush_valid,
      output req_ready, grant_valid, grant_idx, grant_is_muldiv, port_busy
   );

endinterface

// File: rtl/rr_pick_onehot.sv
// rtl/rr_pick_onehot.sv - combinational rotating-priority picker
// Scans req from ptr upward modulo N; returns one-hot grant, its index and a hit flag.
module rr_pick_onehot #(
   parameter int N = 4,
   parameter int W = $clog2(N)
) (
   input  logic [N-1:0] req_i,
   input  logic [W-1:0] ptr_i,
   output logic [N-1:0] gnt_o,
   output logic [W-1:0] idx_o,
   output logic         any_o
);

   int j;

   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      any_o = 1'b0;
      j     = 0;
      for (int k = 0; k < N; k++) begin
         j = (int'(ptr_i) + k) % N;
         if (!any_o && req_i[j]) begin
            any_o    = 1'b1;
            gnt_o[j] = 1'b1;
            idx_o    = W'(j);
         end
      end
   end

endmodule

// File: rtl/exu_port_scheduler.sv
// rtl/exu_port_scheduler.sv - arbitrates one EXU issue port among NUM_REQ issue queues
// Round-robin by default; oldest-ROB-first when ISSUE_SCHED_AGE_PRIO_EN is defined.
module exu_port_scheduler
   import exu_port_scheduler_pkg::*;
#(
   parameter int NUM_REQ    = 4,
   parameter int MULDIV_LAT = 8
) (
   input logic                  clock,
   input logic                  reset,
   exu_port_scheduler_if.slave  bus
);

   localparam int IDX_W = $clog2(NUM_REQ);
   localparam int CNT_W = $clog2(MULDIV_LAT + 1);

   logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic [CNT_W-1:0]   busy_cnt_q, busy_cnt_d;
   logic               port_busy_q, port_busy_d;
   logic               grant_valid_q, grant_valid_d;
   logic [IDX_W-1:0]   grant_idx_q, grant_idx_d;
   logic               grant_is_muldiv_q, grant_is_muldiv_d;

   logic [NUM_REQ-1:0] pick_req;
   logic [NUM_REQ-1:0] pick_gnt;
   logic [IDX_W-1:0]   pick_idx;
   logic               pick_any;
   logic               can_issue;
   logic               grant_fire;

`ifdef ISSUE_SCHED_AGE_PRIO_EN
   logic [NUM_REQ-1:0] age_win;
   logic               age_found;
   age_tag_t           tag_i;
   age_tag_t           tag_best;

   // Strictly-older replacement keeps the lowest index on ties
   always_comb begin
      age_win   = '0;
      age_found = 1'b0;
      tag_i     = '0;
      tag_best  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         tag_i = {bus.req_robidx_flag[i], bus.req_robidx[i*ROB_SIZE_LOG +: ROB_SIZE_LOG]};
         if (bus.req_valid[i] &&
             (!age_found || is_older(tag_i.flag, tag_i.idx, tag_best.flag, tag_best.idx))) begin
            age_found  = 1'b1;
            tag_best   = tag_i;
            age_win    = '0;
            age_win[i] = 1'b1;
         end
      end
   end

   assign pick_req = age_win;
`else
   logic unused_age;
   assign unused_age = ^{bus.req_robidx_flag, bus.req_robidx};
   assign pick_req   = bus.req_valid;
`endif

   // In age mode the picker only encodes an already one-hot winner; rr_ptr stays 0
   rr_pick_onehot #(.N(NUM_REQ), .W(IDX_W)) u_pick (
      .req_i (pick_req),
      .ptr_i (rr_ptr_q),
      .gnt_o (pick_gnt),
      .idx_o (pick_idx),
      .any_o (pick_any)
   );

   assign can_issue     = bus.exu_ready & ~port_busy_q & ~bus.flush_valid;
   assign grant_fire    = can_issue & pick_any;
   assign bus.req_ready = can_issue ? pick_gnt : '0;

   always_comb begin
      rr_ptr_d = rr_ptr_q;
`ifndef ISSUE_SCHED_AGE_PRIO_EN
      if (grant_fire) begin
         rr_ptr_d = (pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
      end
`endif
   end

   always_comb begin
      busy_cnt_d  = busy_cnt_q;
      port_busy_d = port_busy_q;
      if (bus.flush_valid) begin
         busy_cnt_d  = '0;
         port_busy_d = 1'b0;
      end else if (grant_fire && bus.req_is_muldiv[pick_idx] && (MULDIV_LAT > 1)) begin
         busy_cnt_d  = CNT_W'(MULDIV_LAT - 1);
         port_busy_d = 1'b1;
      end else if (busy_cnt_q != '0) begin
         busy_cnt_d  = busy_cnt_q - 1'b1;
         port_busy_d = (busy_cnt_q != CNT_W'(1));
      end
   end

   always_comb begin
      grant_valid_d     = grant_fire;
      grant_idx_d       = grant_fire ? pick_idx : grant_idx_q;
      grant_is_muldiv_d = grant_fire & bus.req_is_muldiv[pick_idx];
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         rr_ptr_q          <= '0;
         busy_cnt_q        <= '0;
         port_busy_q       <= 1'b0;
         grant_valid_q     <= 1'b0;
         grant_idx_q       <= '0;
         grant_is_muldiv_q <= 1'b0;
      end else begin
         rr_ptr_q          <= rr_ptr_d;
         busy_cnt_q        <= busy_cnt_d;
         port_busy_q       <= port_busy_d;
         grant_valid_q     <= grant_valid_d;
         grant_idx_q       <= grant_idx_d;
         grant_is_muldiv_q <= grant_is_muldiv_d;
      end
   end

   assign bus.grant_valid     = grant_valid_q;
   assign bus.grant_idx       = grant_idx_q;
   assign bus.grant_is_muldiv = grant_is_muldiv_q;
   assign bus.port_busy       = port_busy_q;

endmodule
